// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice: FSM states,
// stage-enable bundle, register-file defaults and the IF/ID flush NOP.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 6;
    localparam int unsigned ZERO_REG       = 0;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(6'b111100);
    localparam stage_ctrl_t CTRL_STALL  = stage_ctrl_t'(6'b001101);
    localparam stage_ctrl_t CTRL_FLUSH  = stage_ctrl_t'(6'b111111);
    localparam stage_ctrl_t CTRL_FROZEN = stage_ctrl_t'(6'b000000);
    localparam stage_ctrl_t CTRL_RESET  = stage_ctrl_t'(6'b000011);

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID sources and the load in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_memrd,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard_c
);

    logic rs_match;
    logic rt_match;
    logic rd_live;

    assign rs_match = id_uses_rs & (id_rs == ex_rd);
    assign rt_match = id_uses_rt & (id_rt == ex_rd);
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign rd_live  = (ex_rd != REG_ADDR_W'(ZERO_REG));
    assign hazard_c = id_valid & ex_memrd & rd_live & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: memory wait > redirect flush > load-use stall.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_memrd,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  redirect,
    input  logic                  dmem_busy,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  idex_we,
    output logic                  exmem_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
);

    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1)   ? 2'(FLUSH_CYCLES - 2)   : 2'd0;
    localparam logic [1:0] STALL_RELOAD = (LOAD_USE_STALL > 1) ? 2'(LOAD_USE_STALL - 2) : 2'd0;

    hz_state_e   state_q, state_d;
    hz_state_e   saved_q, saved_d;
    hz_state_e   eff_state;
    logic [1:0]  cnt_q, cnt_d;
    stage_ctrl_t ctrl;
    logic        hazard;
    logic        stall_row;
    logic        flush_row;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memrd   (ex_memrd),
        .ex_rd      (ex_rd),
        .hazard_c   (hazard)
    );

    // FSM state, remaining-cycle count and the state held across a memory wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    // While waiting, the saved state decides what happens once busy drops.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        cnt_d     = cnt_q;
        ctrl      = CTRL_RUN;
        stall_row = 1'b0;
        flush_row = 1'b0;
        if (!rst_n) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
            saved_d = RUN;
            cnt_d   = 2'd0;
        end else if (dmem_busy) begin
            ctrl    = CTRL_FROZEN;
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else if (redirect) begin
            ctrl      = CTRL_FLUSH;
            flush_row = 1'b1;
            state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d     = FLUSH_RELOAD;
        end else begin
            case (eff_state)
                FLUSH: begin
                    ctrl      = CTRL_FLUSH;
                    flush_row = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                LU_STALL: begin
                    ctrl      = CTRL_STALL;
                    stall_row = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d = LU_STALL;
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (hazard) begin
                        ctrl      = CTRL_STALL;
                        stall_row = 1'b1;
                        state_d   = (LOAD_USE_STALL > 1) ? LU_STALL : RUN;
                        cnt_d     = STALL_RELOAD;
                    end
                end
            endcase
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign idex_we     = ctrl.idex_we;
    assign exmem_we    = ctrl.exmem_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign state       = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_row && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_row && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    logic unused_rows;
    assign unused_rows  = stall_row ^ flush_row;
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build (LOAD_USE_STALL=1) plus a LOAD_USE_STALL=3 instance.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned CW = 16;

    localparam logic [5:0] V_RUN    = 6'b111100;
    localparam logic [5:0] V_STALL  = 6'b001101;
    localparam logic [5:0] V_FLUSH  = 6'b111111;
    localparam logic [5:0] V_FROZEN = 6'b000000;
    localparam logic [5:0] V_RESET  = 6'b000011;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt;
    logic          ex_memrd;
    logic [AW-1:0] ex_rd;
    logic          redirect;
    logic          dmem_busy;

    logic          pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles, flush_cycles;
    logic          pc_we3, ifid_we3, idex_we3, exmem_we3, ifid_flush3, idex_bubble3;
    logic [1:0]    state3;
    logic [CW-1:0] stall_cycles3, flush_cycles3;

    logic [5:0]    ctl, ctl3;
    logic [CW-1:0] exp_cnt;
    int            total = 0;
    int            bad   = 0;

    assign ctl  = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble};
    assign ctl3 = {pc_we3, ifid_we3, idex_we3, exmem_we3, ifid_flush3, idex_bubble3};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_USE_STALL(1), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .redirect(redirect), .dmem_busy(dmem_busy), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_we(idex_we), .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .state(state), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_USE_STALL(3), .FLUSH_CYCLES(2), .CNT_W(CW)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .redirect(redirect), .dmem_busy(dmem_busy), .pc_we(pc_we3), .ifid_we(ifid_we3),
        .idex_we(idex_we3), .exmem_we(exmem_we3), .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3),
        .state(state3), .stall_cycles(stall_cycles3), .flush_cycles(flush_cycles3)
    );

    task automatic quiet();
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rt      = '0;
        id_uses_rs = 1'b0;
        id_uses_rt = 1'b0;
        ex_memrd   = 1'b0;
        ex_rd      = '0;
        redirect   = 1'b0;
        dmem_busy  = 1'b0;
    endtask

    // Advance to the next cycle's drive point (just after the falling edge).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic load_in_ex(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic urs,
                              input logic [AW-1:0] rt, input logic urt);
        id_valid = 1'b1; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        ex_memrd = 1'b1; ex_rd = rd;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        next_cycle(); #1;
        total++;
        if (ctl !== V_RESET) begin bad++; $display("FAIL reset_outputs got=%b want=%b", ctl, V_RESET); end
        next_cycle(); #1;
        total++;
        if (state !== 2'd0 || stall_cycles !== '0 || flush_cycles !== '0) begin
            bad++; $display("FAIL reset_state got state=%0d stall=%0d flush=%0d want 0/0/0", state, stall_cycles, flush_cycles);
        end
        rst_n = 1'b1;
        next_cycle(); #1;
        total++;
        if (ctl !== V_RUN || state !== 2'd0) begin bad++; $display("FAIL first_run got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_RUN); end
    endtask

    task automatic test_load_use();
        load_in_ex(6'd5, 6'd5, 1'b1, 6'd0, 1'b0);
        #1;
        total++;
        if (ctl !== V_STALL || state !== 2'd0) begin bad++; $display("FAIL lu_stall got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_STALL); end
        next_cycle();
        ex_memrd = 1'b0;
        #1;
        total++;
        if (ctl !== V_RUN || state !== 2'd0) begin bad++; $display("FAIL lu_release got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_RUN); end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        load_in_ex(6'd0, 6'd0, 1'b1, 6'd0, 1'b1);
        #1;
        total++;
        if (ctl !== V_RUN) begin bad++; $display("FAIL r0_no_stall got=%b want=%b", ctl, V_RUN); end
        next_cycle();
        load_in_ex(6'd5, 6'd3, 1'b1, 6'd5, 1'b0);
        #1;
        total++;
        if (ctl !== V_RUN) begin bad++; $display("FAIL rt_unused got=%b want=%b", ctl, V_RUN); end
        next_cycle();
        load_in_ex(6'd5, 6'd5, 1'b1, 6'd5, 1'b1);
        id_valid = 1'b0;
        #1;
        total++;
        if (ctl !== V_RUN) begin bad++; $display("FAIL id_invalid got=%b want=%b", ctl, V_RUN); end
        next_cycle();
        load_in_ex(6'd42, 6'd3, 1'b1, 6'd42, 1'b1);
        #1;
        total++;
        if (ctl !== V_STALL) begin bad++; $display("FAIL rt_stall got=%b want=%b", ctl, V_STALL); end
        next_cycle();
        quiet();
        #1;
        exp_cnt = PERF ? CW'(2) : CW'(0);
        total++;
        if (stall_cycles !== exp_cnt) begin bad++; $display("FAIL stall_count got=%0d want=%0d", stall_cycles, exp_cnt); end
        repeat (4) next_cycle();
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        #1;
        total++;
        if (ctl !== V_FLUSH || state !== 2'd0) begin bad++; $display("FAIL redir_first got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_FLUSH); end
        next_cycle();
        redirect = 1'b0;
        #1;
        total++;
        if (ctl !== V_FLUSH || state !== 2'd2) begin bad++; $display("FAIL redir_second got ctl=%b st=%0d want ctl=%b st=2", ctl, state, V_FLUSH); end
        next_cycle(); #1;
        total++;
        if (ctl !== V_RUN || state !== 2'd0) begin bad++; $display("FAIL redir_done got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_RUN); end
        exp_cnt = PERF ? CW'(2) : CW'(0);
        total++;
        if (flush_cycles !== exp_cnt) begin bad++; $display("FAIL flush_count got=%0d want=%0d", flush_cycles, exp_cnt); end
        next_cycle();
    endtask

    task automatic test_redirect_wins_then_wait();
        load_in_ex(6'd7, 6'd7, 1'b1, 6'd0, 1'b0);
        redirect = 1'b1;
        #1;
        total++;
        if (ctl !== V_FLUSH) begin bad++; $display("FAIL redir_over_hazard got=%b want=%b", ctl, V_FLUSH); end
        next_cycle();
        quiet();
        dmem_busy = 1'b1;
        #1;
        total++;
        if (state !== 2'd2 || ctl !== V_FROZEN) begin bad++; $display("FAIL wait_entry got ctl=%b st=%0d want ctl=%b st=2", ctl, state, V_FROZEN); end
        next_cycle();
        redirect = 1'b1;
        #1;
        total++;
        if (state !== 2'd3 || ctl !== V_FROZEN) begin bad++; $display("FAIL wait_mid got ctl=%b st=%0d want ctl=%b st=3", ctl, state, V_FROZEN); end
        next_cycle();
        redirect = 1'b0;
        #1;
        total++;
        if (ctl !== V_FROZEN) begin bad++; $display("FAIL wait_last got=%b want=%b", ctl, V_FROZEN); end
        next_cycle();
        dmem_busy = 1'b0;
        #1;
        total++;
        if (ctl !== V_FLUSH) begin bad++; $display("FAIL wait_resume got=%b want=%b", ctl, V_FLUSH); end
        next_cycle(); #1;
        total++;
        if (ctl !== V_RUN || state !== 2'd0) begin bad++; $display("FAIL wait_done got ctl=%b st=%0d want ctl=%b st=0", ctl, state, V_RUN); end
        exp_cnt = PERF ? CW'(4) : CW'(0);
        total++;
        if (flush_cycles !== exp_cnt) begin bad++; $display("FAIL flush_count2 got=%0d want=%0d", flush_cycles, exp_cnt); end
        repeat (4) next_cycle();
    endtask

    task automatic test_stall3();
        load_in_ex(6'd9, 6'd0, 1'b0, 6'd9, 1'b1);
        #1;
        total++;
        if (ctl3 !== V_STALL || state3 !== 2'd0) begin bad++; $display("FAIL s3_c1 got ctl=%b st=%0d want ctl=%b st=0", ctl3, state3, V_STALL); end
        next_cycle();
        ex_memrd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ctl3 !== V_STALL || state3 !== 2'd1) begin bad++; $display("FAIL s3_hold%0d got ctl=%b st=%0d want ctl=%b st=1", i, ctl3, state3, V_STALL); end
            next_cycle();
        end
        #1;
        total++;
        if (ctl3 !== V_RUN || state3 !== 2'd0) begin bad++; $display("FAIL s3_done got ctl=%b st=%0d want ctl=%b st=0", ctl3, state3, V_RUN); end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        load_in_ex(6'd5, 6'd5, 1'b1, 6'd0, 1'b0);
        next_cycle();
        quiet();
        #1;
        total++;
        if (state3 !== 2'd1) begin bad++; $display("FAIL mid_stall_entry got st=%0d want st=1", state3); end
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl3 !== V_RESET) begin bad++; $display("FAIL mid_stall_rst got=%b want=%b", ctl3, V_RESET); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (state3 !== 2'd0 || ctl3 !== V_RUN) begin bad++; $display("FAIL post_rst got ctl=%b st=%0d want ctl=%b st=0", ctl3, state3, V_RUN); end
        total++;
        if (stall_cycles3 !== '0 || flush_cycles3 !== '0 || stall_cycles !== '0 || flush_cycles !== '0) begin
            bad++; $display("FAIL post_rst_counts got %0d/%0d/%0d/%0d want 0", stall_cycles3, flush_cycles3, stall_cycles, flush_cycles);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_redirect_wins_then_wait();
        test_stall3();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
